hash_msg_streamer: RTL and testbench
====================================

Name: hash_msg_streamer

Overview:
Transmit-side front end for the DES-S-box hash core. It accepts a message length and a stream of message bytes from upstream and buffers them in a FIFO. It drives the core's byte interface (M_valid, message, counter) at the strict cadence the core requires, then captures the 32-bit digest when the core raises hash_ready and presents it upstream with a valid/ack handshake.

Parameters:
FIFO_DEPTH, 16, byte FIFO entries; power of 2, minimum 2.
TIMEOUT, 8, maximum cycles spent in WAIT_DIG before err_timeout is raised.

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  one-cycle pulse that begins a message; ignored while busy=1
msg_len  in  64  message length in bytes; sampled on the start cycle
busy  out  1  high from the start cycle until return to IDLE
in_valid  in  1  upstream byte valid
in_data  in  8  upstream byte
in_ready  out  1  FIFO can accept a byte
core_M_valid  out  1  drives the core's M_valid input
core_message  out  8  drives the core's message input
core_counter  out  64  drives the core's counter input
core_hash_ready  in  1  core's hash_ready output
core_digest  in  32  core's digest_out output
digest  out  32  captured digest
digest_valid  out  1  digest available; held until digest_ack
digest_ack  in  1  upstream consumes the digest
err_underrun  out  1  sticky FIFO-underrun error
err_timeout  out  1  sticky digest-timeout error

Behaviour:
- Clocking and reset: one clock, clk. Asynchronous active-low reset, rst_n.
- Reset values: state=IDLE; all outputs 0; FIFO empty; counters cleared.
- Core constraint (hard rule): once a message starts, the core must see bytes on every second cycle (M_valid high, low, high, ...). A missed slot corrupts core state. core_counter must stay constant for the whole message.
- Byte intake:
  - in_ready = busy & ~err & (fifo not full) & (accepted < len_q).
  - A push happens when in_valid & in_ready. accepted is a 64-bit counter.
  - Push and pop in the same cycle are allowed.
- core_counter = len_q. It is latched on start and held until IDLE.
- core_message = FIFO head during SEND, otherwise 0.
- core_M_valid = 1 only in SEND (Moore output).
- State machine:
  - IDLE: on start, latch len_q=msg_len, set remaining=msg_len, go to PREFILL. Bytes may be pushed starting in the start cycle.
  - PREFILL: wait until fifo_count >= min(len_q, FIFO_DEPTH), then go to SEND. When len_q=0 this exits on the next cycle.
  - SEND:
    - len_q=0: drive a single M_valid with message 0, then go to WAIT_DIG.
    - FIFO empty (len_q>0): assert err_underrun, M_valid=0, go to ERR.
    - Otherwise: pop, remaining-1. If remaining was 1, go to WAIT_DIG; else go to GAP.
  - GAP: exactly one cycle with M_valid=0, then go to SEND.
  - WAIT_DIG:
    - If core_hash_ready=1: register digest<=core_digest, digest_valid<=1, go to DONE.
    - Otherwise increment the timeout counter. Reaching TIMEOUT sets err_timeout and goes to ERR.
    - Nominal wait: core_hash_ready rises 3 cycles after the last SEND cycle.
  - DONE: hold digest and digest_valid. On digest_ack, clear digest_valid and go to IDLE. busy is 0 from the next cycle.
  - ERR: sticky until rst_n. busy=1, in_ready=0, M_valid=0, digest_valid=0.
- Start pulses outside IDLE are ignored, with no side effects.
- Reset mid-message returns to IDLE immediately and flushes the FIFO. The system resets the core on the same rst_n.
- Throughput: after prefill, upstream must supply at least 1 byte per 2 cycles, otherwise underrun.

Test Plan:
- Nominal: start with len=3; push 0x61,0x62,0x63 in cycles 0-2.
  - Required: SEND at cycles 4, 6, 8 with core_message 0x61/0x62/0x63; core_counter=3 throughout.
  - A core model raises hash_ready at cycle 11 → digest_valid=1 at cycle 12 with digest=core_digest; ack → busy=0.
- Zero length: start with len=0 → exactly one M_valid pulse with message=0x00 and counter=0; digest captured 3 cycles later.
- Back-pressure: len=20, FIFO_DEPTH=16, in_valid held high.
  - Required: in_ready drops after 16 bytes; SEND begins once 16 bytes are buffered.
  - All 20 bytes are emitted on alternating cycles in order; no more than 20 bytes are accepted.
- Underrun: len=20, upstream stops after 17 bytes → err_underrun=1, M_valid stays 0, busy=1 until rst_n.
- Timeout: the core stub never asserts hash_ready, len=1 → err_timeout=1 exactly TIMEOUT=8 cycles after entering WAIT_DIG; digest_valid stays 0.
- Reset/ignore: start during SEND is ignored (len_q unchanged). Asserting rst_n low mid-GAP → all outputs 0, FIFO empty, next start works normally.

Source files
------------

// File: rtl/hash_msg_streamer.sv
// ---------------------------------------------------------------------------
// hash_msg_streamer
//
// Transmit-side front end for the DES-S-box hash core. Buffers an upstream
// byte stream in a small FIFO, replays it to the core at the strict
// one-byte-every-second-cycle cadence the core needs, then captures the
// 32-bit digest and hands it upstream with a valid/ack handshake.
//
// Parameters
//   FIFO_DEPTH  byte FIFO entries (power of 2, >= 2)
//   TIMEOUT     max cycles spent waiting for core_hash_ready
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, msg_len    begin a message of msg_len bytes (ignored while busy)
//   busy              high from the start cycle until back in IDLE
//   in_valid/in_data  upstream byte stream
//   in_ready          a byte can be accepted this cycle
//   core_M_valid      core byte strobe (high in SEND only)
//   core_message      core byte (FIFO head during SEND, else 0)
//   core_counter      message length, constant for the whole message
//   core_hash_ready   core signals digest is ready
//   core_digest       core digest output
//   digest            captured digest
//   digest_valid      digest available, held until digest_ack
//   digest_ack        upstream consumes the digest
//   err_underrun      sticky: FIFO ran dry at a core byte slot
//   err_timeout       sticky: core never raised hash_ready
// ---------------------------------------------------------------------------
module hash_msg_streamer #(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] msg_len,
  output logic        busy,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        core_M_valid,
  output logic [7:0]  core_message,
  output logic [63:0] core_counter,
  input  logic        core_hash_ready,
  input  logic [31:0] core_digest,
  output logic [31:0] digest,
  output logic        digest_valid,
  input  logic        digest_ack,
  output logic        err_underrun,
  output logic        err_timeout
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [63:0]   DEPTH_64 = 64'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_SEND,
    S_GAP,
    S_WAIT_DIG,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_reg, state_next;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;

  // Message bookkeeping
  logic [63:0]   len_reg;
  logic [63:0]   remaining_reg;
  logic [63:0]   accepted_reg;
  logic [TW-1:0] tmo_reg;

  // Digest / error registers
  logic [31:0]   digest_reg;
  logic          digest_valid_reg;
  logic          err_underrun_reg;
  logic          err_timeout_reg;

  // Combinational helpers
  logic          idle;
  logic          fifo_full;
  logic          fifo_empty;
  logic          err_any;
  logic [63:0]   len_eff;
  logic [63:0]   prefill_thresh;
  logic          prefill_done;
  logic          push;
  logic          pop;
  logic          set_underrun;
  logic          set_timeout;
  logic          capture;
  logic          release_digest;

  assign idle       = (state_reg == S_IDLE);
  assign fifo_full  = (count_reg == DEPTH_C);
  assign fifo_empty = (count_reg == '0);
  assign err_any    = err_underrun_reg | err_timeout_reg;

  // busy is already high in the start cycle so upstream can push a byte
  // on the very same edge that starts the message.
  assign busy = ~idle | start;

  // In the start cycle len_reg still holds the previous message length,
  // so the intake limit must come straight from msg_len.
  assign len_eff = idle ? msg_len : len_reg;

  assign in_ready = busy & ~err_any & ~fifo_full & (accepted_reg < len_eff);
  assign push     = in_valid & in_ready;

  // Cadence only starts once min(len, depth) bytes are buffered; from then
  // on upstream must keep up with one byte every two cycles.
  assign prefill_thresh = (len_reg > DEPTH_64) ? DEPTH_64 : len_reg;
  assign prefill_done   = (64'(count_reg) >= prefill_thresh);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and control outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    core_M_valid   = 1'b0;
    pop            = 1'b0;
    set_underrun   = 1'b0;
    set_timeout    = 1'b0;
    capture        = 1'b0;
    release_digest = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_PREFILL;
        end
      end

      S_PREFILL: begin
        if (prefill_done) begin
          state_next = S_SEND;
        end
      end

      S_SEND: begin
        if (len_reg == 64'd0) begin
          // Empty message: the core still needs one strobe with a 0 byte.
          core_M_valid = 1'b1;
          state_next   = S_WAIT_DIG;
        end else if (fifo_empty) begin
          // Missing a slot would corrupt the core, so stop for good.
          set_underrun = 1'b1;
          state_next   = S_ERR;
        end else begin
          core_M_valid = 1'b1;
          pop          = 1'b1;
          state_next   = (remaining_reg == 64'd1) ? S_WAIT_DIG : S_GAP;
        end
      end

      S_GAP: begin
        state_next = S_SEND;
      end

      S_WAIT_DIG: begin
        if (core_hash_ready) begin
          capture    = 1'b1;
          state_next = S_DONE;
        end else if (tmo_reg == TMO_LAST) begin
          set_timeout = 1'b1;
          state_next  = S_ERR;
        end
      end

      S_DONE: begin
        if (digest_ack) begin
          release_digest = 1'b1;
          state_next     = S_IDLE;
        end
      end

      S_ERR: begin
        state_next = S_ERR;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FIFO storage (no reset needed; pointers define contents)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Message length, byte counters and timeout counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_reg       <= '0;
      remaining_reg <= '0;
      accepted_reg  <= '0;
      tmo_reg       <= '0;
    end else begin
      if (idle && start) begin
        len_reg       <= msg_len;
        remaining_reg <= msg_len;
      end else if (pop) begin
        remaining_reg <= remaining_reg - 64'd1;
      end

      // accepted restarts from zero for every message; a byte pushed in
      // the start cycle is the first one counted.
      if (idle) begin
        accepted_reg <= push ? 64'd1 : 64'd0;
      end else if (push) begin
        accepted_reg <= accepted_reg + 64'd1;
      end

      if ((state_reg == S_WAIT_DIG) && !core_hash_ready) begin
        tmo_reg <= tmo_reg + TW'(1);
      end else begin
        tmo_reg <= '0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Digest capture and sticky errors
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digest_reg       <= '0;
      digest_valid_reg <= 1'b0;
      err_underrun_reg <= 1'b0;
      err_timeout_reg  <= 1'b0;
    end else begin
      if (capture) begin
        digest_reg       <= core_digest;
        digest_valid_reg <= 1'b1;
      end else if (release_digest) begin
        digest_valid_reg <= 1'b0;
      end
      if (set_underrun) begin
        err_underrun_reg <= 1'b1;
      end
      if (set_timeout) begin
        err_timeout_reg <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  assign core_message = ((state_reg == S_SEND) && !fifo_empty) ? mem[rd_ptr_reg] : 8'h00;
  assign core_counter = len_reg;
  assign digest       = digest_reg;
  assign digest_valid = digest_valid_reg;
  assign err_underrun = err_underrun_reg;
  assign err_timeout  = err_timeout_reg;

endmodule

// File: tb/tb_hash_msg_streamer.sv
// ---------------------------------------------------------------------------
// tb_hash_msg_streamer
//
// Directed sequence of message scenarios with randomized byte data,
// upstream gaps and digest values. A reference model (byte queue plus
// cycle arithmetic on the core cadence) predicts every output each cycle.
// A simple core stub raises hash_ready 3 cycles after the final strobe.
// ---------------------------------------------------------------------------
module tb_hash_msg_streamer;

  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] msg_len;
  logic        busy;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        core_M_valid;
  logic [7:0]  core_message;
  logic [63:0] core_counter;
  logic        core_hash_ready;
  logic [31:0] core_digest;
  logic [31:0] digest;
  logic        digest_valid;
  logic        digest_ack;
  logic        err_underrun;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  hash_msg_streamer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .msg_len         (msg_len),
    .busy            (busy),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .core_M_valid    (core_M_valid),
    .core_message    (core_message),
    .core_counter    (core_counter),
    .core_hash_ready (core_hash_ready),
    .core_digest     (core_digest),
    .digest          (digest),
    .digest_valid    (digest_valid),
    .digest_ack      (digest_ack),
    .err_underrun    (err_underrun),
    .err_timeout     (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string where);
    chk(64'(busy),         64'd0, {where, "_busy"});
    chk(64'(in_ready),     64'd0, {where, "_in_ready"});
    chk(64'(core_M_valid), 64'd0, {where, "_m_valid"});
    chk(64'(core_message), 64'd0, {where, "_message"});
    chk(core_counter,      64'd0, {where, "_counter"});
    chk(64'(digest),       64'd0, {where, "_digest"});
    chk(64'(digest_valid), 64'd0, {where, "_digest_valid"});
    chk(64'(err_underrun), 64'd0, {where, "_err_underrun"});
    chk(64'(err_timeout),  64'd0, {where, "_err_timeout"});
  endtask

  task automatic do_reset(input string where);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; digest_ack = 1'b0; core_hash_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero(where);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("reset %s done", where);
  endtask

  // One message transaction. The model predicts, per cycle, the byte
  // queue contents, the core byte slots and all handshake/error outputs.
  task automatic run_msg(input int len, input int vprob, input int supply,
                         input bit core_ok, input int base, input bit poke,
                         input int abort_n, input string name,
                         output int obs_first, output int obs_dv, output bit ended_err);
    logic [7:0]  q[$];
    logic [7:0]  exp_msg;
    logic [31:0] dig;
    int nsend, fill_target, first_send, sends, last, last_slot, u_cyc;
    int accepted, ack_cyc, dly;
    bit err_flag, done, exp_ready, slot, exp_mv, exp_dv, exp_et, exp_eu;

    nsend       = (len == 0) ? 1 : len;
    fill_target = (len < DEPTH) ? len : DEPTH;
    first_send  = -1; sends = 0; last = -1; last_slot = -1; u_cyc = -1;
    accepted    = 0; ack_cyc = -1; dly = $urandom_range(0, 2);
    err_flag    = 1'b0; done = 1'b0;
    dig         = $urandom;
    obs_first   = -1; obs_dv = -1; ended_err = 1'b0;

    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (abort_n > 0 && sends == abort_n && c == last_slot + 1) begin
        start = 1'b0; in_valid = 1'b0; digest_ack = 1'b0; core_hash_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero({name, "_abort"});
        @(negedge clk);
        rst_n = 1'b1;
        done  = 1'b1;
      end else begin
        start           = (c == 0) || (poke && first_send >= 0 && c == first_send + 2);
        msg_len         = (c == 0) ? 64'(len) : {$urandom, $urandom};
        in_data         = (base >= 0) ? 8'(base + accepted) : 8'($urandom);
        in_valid        = (accepted < supply) && ($urandom_range(0, 99) < vprob);
        core_hash_ready = core_ok && last >= 0 && c == last + 3;
        core_digest     = (last >= 0 && c == last + 3) ? dig : $urandom;
        digest_ack      = (ack_cyc >= 0 && c == ack_cyc);
        #1;
        if (ack_cyc >= 0 && c == ack_cyc + 1) begin
          chk(64'(busy),         64'd0, $sformatf("%s_busy_after_ack", name));
          chk(64'(digest_valid), 64'd0, $sformatf("%s_dv_after_ack", name));
          done = 1'b1;
        end else begin
          exp_ready = !err_flag && q.size() < DEPTH && accepted < len;
          if (first_send < 0 && c >= 1 && q.size() >= fill_target) begin
            first_send = c + 1;
          end
          slot    = !err_flag && first_send >= 0 && c >= first_send &&
                    ((c - first_send) % 2 == 0) && sends < nsend;
          exp_mv  = 1'b0;
          exp_msg = 8'h00;
          if (slot) begin
            if (len == 0) begin
              exp_mv = 1'b1;
              sends++;
            end else if (q.size() == 0) begin
              u_cyc = c;
            end else begin
              exp_mv  = 1'b1;
              exp_msg = q.pop_front();
              sends++;
            end
            if (exp_mv) begin
              last_slot = c;
              if (sends == nsend) begin
                last    = c;
                ack_cyc = core_ok ? c + 4 + dly : -1;
              end
            end
          end
          exp_dv = core_ok && last >= 0 && c >= last + 4;
          exp_et = !core_ok && last >= 0 && c >= last + 1 + TMO;
          exp_eu = u_cyc >= 0 && c > u_cyc;

          chk(64'(busy),         64'd1,         $sformatf("%s_busy@%0d", name, c));
          chk(64'(in_ready),     64'(exp_ready), $sformatf("%s_in_ready@%0d", name, c));
          chk(64'(core_M_valid), 64'(exp_mv),    $sformatf("%s_m_valid@%0d", name, c));
          chk(64'(core_message), 64'(exp_msg),   $sformatf("%s_message@%0d", name, c));
          if (c >= 1) chk(core_counter, 64'(len), $sformatf("%s_counter@%0d", name, c));
          chk(64'(digest_valid), 64'(exp_dv),    $sformatf("%s_digest_valid@%0d", name, c));
          if (exp_dv) chk(64'(digest), 64'(dig), $sformatf("%s_digest@%0d", name, c));
          chk(64'(err_underrun), 64'(exp_eu),    $sformatf("%s_err_underrun@%0d", name, c));
          chk(64'(err_timeout),  64'(exp_et),    $sformatf("%s_err_timeout@%0d", name, c));

          if (core_M_valid && obs_first < 0) obs_first = c;
          if (digest_valid && obs_dv < 0)    obs_dv = c;

          if (in_valid && exp_ready) begin
            q.push_back(in_data);
            accepted++;
          end
          err_flag = (u_cyc >= 0);
          if (u_cyc >= 0 && c >= u_cyc + 6) begin
            ended_err = 1'b1;
            done      = 1'b1;
          end
          if (!core_ok && last >= 0 && c >= last + TMO + 4) begin
            ended_err = 1'b1;
            done      = 1'b1;
          end
        end
      end
    end
    $display("msg %s len=%0d first_send=%0d digest_valid_at=%0d err=%0d", name, len, obs_first, obs_dv, ended_err);
  endtask

  initial begin
    int f, dv, len;
    int probs[3];
    bit e;
    probs = '{60, 85, 100};
    start = 1'b0; msg_len = '0; in_valid = 1'b0; in_data = '0;
    core_hash_ready = 1'b0; core_digest = '0; digest_ack = 1'b0;
    rst_n = 1'b0;

    do_reset("initial");

    // Nominal 3-byte message "abc"
    run_msg(3, 100, 3, 1'b1, 'h61, 1'b0, 0, "nominal", f, dv, e);
    chk(64'(f),  64'd4,  "nominal_first_send_cycle");
    chk(64'(dv), 64'd12, "nominal_digest_valid_cycle");

    // Zero-length message
    run_msg(0, 100, 0, 1'b1, -1, 1'b0, 0, "zero_len", f, dv, e);
    chk(64'(f),  64'd2, "zero_len_send_cycle");
    chk(64'(dv), 64'd6, "zero_len_digest_valid_cycle");

    // Back-pressure: more bytes offered than the FIFO holds
    run_msg(20, 100, 1000, 1'b1, 'h10, 1'b0, 0, "backpressure", f, dv, e);
    chk(64'(f), 64'd17, "backpressure_first_send_cycle");

    // Underrun: upstream stops after 17 bytes
    run_msg(20, 100, 17, 1'b1, -1, 1'b0, 0, "underrun", f, dv, e);
    do_reset("after_underrun");

    // Timeout: core never answers
    run_msg(1, 100, 1000, 1'b0, -1, 1'b0, 0, "timeout", f, dv, e);
    do_reset("after_timeout");

    // Start pulse during SEND must be ignored
    run_msg(6, 100, 1000, 1'b1, 'h30, 1'b1, 0, "start_ignored", f, dv, e);

    // Reset in the first GAP, then a normal message
    run_msg(5, 100, 1000, 1'b1, 'h40, 1'b0, 1, "abort_gap", f, dv, e);
    run_msg(3, 100, 3, 1'b1, 'h61, 1'b0, 0, "after_abort", f, dv, e);
    chk(64'(f), 64'd4, "after_abort_first_send_cycle");

    // Randomized messages
    for (int i = 0; i < 8; i++) begin
      len = $urandom_range(0, 40);
      run_msg(len, probs[$urandom_range(0, 2)], 1000, 1'b1, -1, 1'b0, 0,
              $sformatf("random%0d", i), f, dv, e);
      if (e) do_reset($sformatf("after_random%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
